// File: rtl/arb_pkg.sv
// Shared definitions for the lock-arbiter family.
//   arb_state_e      : arbiter FSM states (IDLE, OWNED, RELEASE)
//   ArbDefaultPorts  : default requester count
//   ArbMaxPorts      : widest port vector onehot_f can produce
//   onehot_f         : index -> one-hot vector (ArbMaxPorts wide, truncate at use site)
package arb_pkg;

    localparam int unsigned ArbDefaultPorts = 4;
    localparam int unsigned ArbMaxPorts     = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWNED   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    function automatic logic [ArbMaxPorts-1:0] onehot_f(input int unsigned idx);
        return ArbMaxPorts'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: finds the first set bit of req scanning upward
// from ptr, wrapping N-1 -> 0. Purely combinational.
//   req    : request vector (N bits)
//   ptr    : index with highest priority
//   any    : at least one request present
//   idx    : index of the winning request (0 when any=0)
//   onehot : one-hot form of idx (all zeros when any=0)
module rr_pick
    import arb_pkg::*;
#(
    parameter int unsigned N = ArbDefaultPorts,
    localparam int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic            any,
    output logic [IdxW-1:0] idx,
    output logic [N-1:0]    onehot
);

    always_comb begin
        int unsigned cand;
        any  = 1'b0;
        idx  = '0;
        cand = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = (32'(ptr) + i) % N;
            // Only the first hit in scan order wins.
            if (!any && req[IdxW'(cand)]) begin
                any = 1'b1;
                idx = IdxW'(cand);
            end
        end
    end

    assign onehot = any ? N'(onehot_f(32'(idx))) : '0;

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with ownership locking. A granted port keeps the
// resource until it pulses done, drops its request, or (optionally) the
// watchdog forces a release. Every release is followed by one dead cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   req_i      : per-port request level
//   done_i     : per-port completion pulse (owner's bit only)
//   gnt_o      : registered one-hot grant
//   gnt_id_o   : owner index, valid while busy_o
//   busy_o     : a grant is held
//   timeout_o  : one-cycle pulse after a watchdog release
// Build option: define RR_ARB_TIMEOUT_EN to include the hold watchdog
// (TIMEOUT_CYCLES); otherwise timeout_o is tied low.
module rr_lock_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS      = ArbDefaultPorts,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    localparam int unsigned IdxW = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [NUM_PORTS-1:0] done_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [IdxW-1:0]      gnt_id_o,
    output logic                 busy_o,
    output logic                 timeout_o
);

    arb_state_e           state_q, state_d;
    logic [IdxW-1:0]      ptr_q, ptr_d;
    logic [NUM_PORTS-1:0] gnt_q, gnt_d;
    logic [IdxW-1:0]      id_q, id_d;
    logic                 busy_q, busy_d;

    logic                 pick_any;
    logic [IdxW-1:0]      pick_idx;
    logic [NUM_PORTS-1:0] pick_onehot;

    logic                 owner_term;
    logic                 wd_expire;
    logic                 release_now;

    rr_pick #(
        .N (NUM_PORTS)
    ) u_pick (
        .req    (req_i),
        .ptr    (ptr_q),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // Normal termination by the owner: done pulse or abandoned request.
    assign owner_term  = done_i[id_q] | ~req_i[id_q];
    assign release_now = (state_q == OWNED) && (owner_term || wd_expire);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        busy_d  = busy_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_onehot;
                    id_d    = pick_idx;
                    busy_d  = 1'b1;
                    state_d = OWNED;
                end
            end
            OWNED: begin
                if (release_now) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = (id_q == IdxW'(NUM_PORTS - 1)) ? '0 : id_q + 1'b1;
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            id_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt_o    = gnt_q;
    assign gnt_id_o = id_q;
    assign busy_o   = busy_q;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q;

    // Counter holds 0 on the first owned cycle, so expiry at TIMEOUT_CYCLES-1
    // gives exactly TIMEOUT_CYCLES cycles of grant.
    assign wd_expire = (state_q == OWNED) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (state_q == OWNED && !release_now) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            // Done/abandon on the expiry edge wins: not reported as a timeout.
            timeout_q <= release_now & ~owner_term;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_timeout_cfg;

    assign wd_expire          = 1'b0;
    assign timeout_o          = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_rr_lock_arbiter.sv
module tb_rr_lock_arbiter;

    localparam int N = 4;
    localparam int T = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_i, done_i, gnt_o;
    logic [1:0] gnt_id_o;
    logic       busy_o, timeout_o;

    int vectors = 0;
    int errors  = 0;

    // Reference model: who owns the resource, how long, and whether we are in
    // the post-release gap.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_gap   = 0;
    int m_held  = 0;
    bit m_tmo   = 0;

    always #5 clk = ~clk;

    rr_lock_arbiter #(
        .NUM_PORTS      (N),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .done_i    (done_i),
        .gnt_o     (gnt_o),
        .gnt_id_o  (gnt_id_o),
        .busy_o    (busy_o),
        .timeout_o (timeout_o)
    );

    function automatic logic [3:0] exp_gnt();
        return (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    endfunction

    task automatic model_update(input logic r, input logic [3:0] rq, input logic [3:0] dn);
        bit term, wd;
        if (!r) begin
            m_owner = -1; m_ptr = 0; m_gap = 0; m_held = 0; m_tmo = 0;
        end else if (m_owner >= 0) begin
            term = dn[2'(m_owner)] || !rq[2'(m_owner)];
`ifdef RR_ARB_TIMEOUT_EN
            wd = (m_held == T - 1);
`else
            wd = 0;
`endif
            if (term || wd) begin
                m_tmo   = !term;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_gap   = 1;
            end else begin
                m_held++;
                m_tmo = 0;
            end
        end else begin
            m_tmo = 0;
            if (m_gap > 0) begin
                m_gap = 0;
            end else if (rq != 4'b0000) begin
                for (int k = 0; k < N; k++) begin
                    int p;
                    p = (m_ptr + k) % N;
                    if (m_owner < 0 && rq[2'(p)]) begin
                        m_owner = p;
                        m_held  = 0;
                    end
                end
            end
        end
    endtask

    // Drive inputs mid-cycle, advance one edge, settle, update the model.
    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] dn);
        @(negedge clk);
        rst_n  = r;
        req_i  = rq;
        done_i = dn;
        @(posedge clk);
        model_update(r, rq, dn);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 4'b0000, 4'b0000);
        step(1'b0, 4'b0000, 4'b0000);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b1111, 4'b0000);
            vectors++;
            if (gnt_o !== 4'b0000 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: gnt=%b busy=%b, want gnt=0000 busy=0", gnt_o, busy_o);
            end
        end
        step(1'b1, 4'b1111, 4'b0000);
        vectors++;
        if (gnt_o !== 4'b0001 || busy_o !== 1'b1 || gnt_id_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_first_grant: gnt=%b busy=%b id=%0d, want 0001 1 0",
                     gnt_o, busy_o, gnt_id_o);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        step(1'b1, 4'b1111, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (gnt_o !== seq[i]) begin
                errors++;
                $display("FAIL rotation_grant[%0d]: gnt=%b, want %b", i, gnt_o, seq[i]);
            end
            step(1'b1, 4'b1111, 4'b0000);
            vectors++;
            if (gnt_o !== seq[i]) begin
                errors++;
                $display("FAIL rotation_hold[%0d]: gnt=%b, want %b", i, gnt_o, seq[i]);
            end
            step(1'b1, 4'b1111, seq[i]);
            vectors++;
            if (gnt_o !== 4'b0000) begin
                errors++;
                $display("FAIL rotation_gap1[%0d]: gnt=%b, want 0000", i, gnt_o);
            end
            step(1'b1, 4'b1111, 4'b0000);
            vectors++;
            if (gnt_o !== 4'b0000) begin
                errors++;
                $display("FAIL rotation_gap2[%0d]: gnt=%b, want 0000", i, gnt_o);
            end
            step(1'b1, 4'b1111, 4'b0000);
        end
    endtask

    task automatic test_wrap_skip();
        do_reset();
        step(1'b1, 4'b0100, 4'b0000);
        vectors++;
        if (gnt_o !== 4'b0100) begin
            errors++;
            $display("FAIL wrap_first: gnt=%b, want 0100", gnt_o);
        end
        step(1'b1, 4'b0100, 4'b0100);
        step(1'b1, 4'b0011, 4'b0000);
        step(1'b1, 4'b0011, 4'b0000);
        vectors++;
        if (gnt_o !== 4'b0001 || gnt_id_o !== 2'd0) begin
            errors++;
            $display("FAIL wrap_skip: gnt=%b id=%0d, want 0001 0", gnt_o, gnt_id_o);
        end
    endtask

    task automatic test_abandon();
        do_reset();
        step(1'b1, 4'b0010, 4'b0000);
        step(1'b1, 4'b1010, 4'b1000);
        vectors++;
        if (gnt_o !== 4'b0010 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL foreign_done: gnt=%b busy=%b, want 0010 1", gnt_o, busy_o);
        end
        step(1'b1, 4'b1000, 4'b1000);
        vectors++;
        if (gnt_o !== 4'b0000 || busy_o !== 1'b0 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL abandon: gnt=%b busy=%b tmo=%b, want 0000 0 0",
                     gnt_o, busy_o, timeout_o);
        end
    endtask

    task automatic test_watchdog();
        int cnt;
        do_reset();
        step(1'b1, 4'b0011, 4'b0000);
        cnt = 0;
        for (int i = 0; i < 20 && gnt_o === 4'b0001; i++) begin
            cnt++;
            step(1'b1, 4'b0011, 4'b0000);
        end
`ifdef RR_ARB_TIMEOUT_EN
        vectors++;
        if (cnt != T || timeout_o !== 1'b1) begin
            errors++;
            $display("FAIL watchdog_len: cycles=%0d tmo=%b, want %0d 1", cnt, timeout_o, T);
        end
        step(1'b1, 4'b0011, 4'b0000);
        vectors++;
        if (timeout_o !== 1'b0 || gnt_o !== 4'b0000) begin
            errors++;
            $display("FAIL watchdog_pulse: tmo=%b gnt=%b, want 0 0000", timeout_o, gnt_o);
        end
        step(1'b1, 4'b0011, 4'b0000);
        vectors++;
        if (gnt_o !== 4'b0010) begin
            errors++;
            $display("FAIL watchdog_next: gnt=%b, want 0010", gnt_o);
        end
`else
        vectors++;
        if (cnt != 20 || gnt_o !== 4'b0001 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL watchdog_off: cycles=%0d gnt=%b tmo=%b, want 20 0001 0",
                     cnt, gnt_o, timeout_o);
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b1, 4'b0100, 4'b0000);
        step(1'b1, 4'b0100, 4'b0000);
        step(1'b0, 4'b0100, 4'b0000);
        vectors++;
        if (gnt_o !== 4'b0000 || busy_o !== 1'b0 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: gnt=%b busy=%b tmo=%b, want 0000 0 0",
                     gnt_o, busy_o, timeout_o);
        end
        step(1'b1, 4'b1100, 4'b0000);
        vectors++;
        if (gnt_o !== 4'b0100) begin
            errors++;
            $display("FAIL reset_mid_regrant: gnt=%b, want 0100", gnt_o);
        end
    endtask

    task automatic test_random();
        logic [3:0] rq, dn;
        logic       r;
        do_reset();
        rq = 4'b0000;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(7) == 0) rq[b] = ~rq[b];
                dn[b] = ($urandom_range(9) == 0);
            end
            r = ($urandom_range(99) != 0);
            step(r, rq, dn);
            vectors++;
            if (gnt_o !== exp_gnt() || busy_o !== (m_owner >= 0)) begin
                errors++;
                $display("FAIL random_grant[%0d]: gnt=%b busy=%b, want %b %b",
                         c, gnt_o, busy_o, exp_gnt(), (m_owner >= 0));
            end
            vectors++;
            if (timeout_o !== m_tmo) begin
                errors++;
                $display("FAIL random_timeout[%0d]: tmo=%b, want %b", c, timeout_o, m_tmo);
            end
            if (m_owner >= 0) begin
                vectors++;
                if (gnt_id_o !== 2'(m_owner)) begin
                    errors++;
                    $display("FAIL random_id[%0d]: id=%0d, want %0d", c, gnt_id_o, m_owner);
                end
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        req_i  = 4'b0000;
        done_i = 4'b0000;
        test_reset();
        test_rotation();
        test_wrap_skip();
        test_abandon();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL time_limit: simulation still running, want finished");
        $fatal(1);
    end

endmodule
